muldiv_sequencer: RTL and testbench

- Iterative RV32M multiply/divide unit for the EX stage. It is sequenced by a start/stall handshake with the pipeline, alongside the single-cycle ALU.
- While an M-extension operation computes, it holds the pipeline by asserting stall. It presents the result for exactly one cycle.
- One shift-add/shift-subtract datapath is shared by all eight M operations. Operands are converted to magnitudes, processed unsigned, and the sign is fixed up at the end.

---
 rtl/muldiv_sequencer.sv | 166 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: one shared shift-add / restoring-divide datapath
// on operand magnitudes, with sign fix-up applied as the last iteration completes.
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_flush,
    input  logic [2:0]       i_funct3,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    output logic             o_stall,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LastCount = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e           r_state;
    logic [CW-1:0]    r_count;
    logic [2:0]       r_funct3;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH-1:0] r_result;

    logic             w_sign_a;
    logic             w_sign_b;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic             w_div0;
    logic             w_ovf;
    logic [WIDTH-1:0] w_special;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_rem_sh;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_next_hi;
    logic [WIDTH-1:0] w_next_lo;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0] w_quot_fix;
    logic [WIDTH-1:0] w_rem_fix;
    logic [WIDTH-1:0] w_final;

    always_comb begin
        // op_a is signed for everything except MULHU/DIVU/REMU; op_b additionally not for MULHSU
        w_sign_a  = i_op_a[WIDTH-1] & (i_funct3[2] ? ~i_funct3[0] : (i_funct3 != 3'b011));
        w_sign_b  = i_op_b[WIDTH-1] & (i_funct3[2] ? ~i_funct3[0] : ~i_funct3[1]);
        w_mag_a   = w_sign_a ? (~i_op_a + 1'b1) : i_op_a;
        w_mag_b   = w_sign_b ? (~i_op_b + 1'b1) : i_op_b;
        w_div0    = i_funct3[2] & (i_op_b == '0);
        w_ovf     = i_funct3[2] & ~i_funct3[0] & (i_op_b == '1)
                    & (i_op_a == {1'b1, {(WIDTH-1){1'b0}}});
        w_special = '0;
        if (w_div0) begin
            w_special = i_funct3[1] ? i_op_a : '1;
        end else if (!i_funct3[1]) begin
            w_special = {1'b1, {(WIDTH-1){1'b0}}};
        end
    end

    always_comb begin
        w_mul_sum = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_opnd} : '0);
        w_rem_sh  = {r_acc, r_lo[WIDTH-1]};
        w_ge      = (w_rem_sh >= {1'b0, r_opnd});
        w_diff    = w_rem_sh[WIDTH-1:0] - r_opnd;
        if (r_funct3[2]) begin
            w_next_hi = w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
            w_next_lo = {r_lo[WIDTH-2:0], w_ge};
        end else begin
            w_next_hi = w_mul_sum[WIDTH:1];
            w_next_lo = {w_mul_sum[0], r_lo[WIDTH-1:1]};
        end
        w_prod_fix = r_neg_q ? (~{w_next_hi, w_next_lo} + 1'b1) : {w_next_hi, w_next_lo};
        w_quot_fix = r_neg_q ? (~w_next_lo + 1'b1) : w_next_lo;
        w_rem_fix  = r_neg_r ? (~w_next_hi + 1'b1) : w_next_hi;
        unique case (r_funct3)
            3'b000:                 w_final = w_prod_fix[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: w_final = w_prod_fix[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         w_final = w_quot_fix;
            default:                w_final = w_rem_fix;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= StIdle;
            r_count  <= '0;
            r_funct3 <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_acc    <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_start && !i_flush) begin
                        r_funct3 <= i_funct3;
                        r_neg_q  <= w_sign_a ^ w_sign_b;
                        r_neg_r  <= w_sign_a;
                        r_count  <= '0;
                        if (w_div0 || w_ovf) begin
                            r_result <= w_special;
                            r_done   <= 1'b1;
                            r_state  <= StDone;
                        end else begin
                            // multiply: lo holds multiplier; divide: lo holds dividend
                            r_acc   <= '0;
                            r_lo    <= i_funct3[2] ? w_mag_a : w_mag_b;
                            r_opnd  <= i_funct3[2] ? w_mag_b : w_mag_a;
                            r_busy  <= 1'b1;
                            r_state <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    if (i_flush) begin
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end else begin
                        r_acc   <= w_next_hi;
                        r_lo    <= w_next_lo;
                        r_count <= r_count + 1'b1;
                        if (r_count == LastCount) begin
                            r_result <= w_final;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= StDone;
                        end
                    end
                end
                StDone: begin
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        o_stall = ((r_state == StIdle) && i_start && !i_flush) || (r_state == StCalc);
    end

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_result = r_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table, reference model for random
// operands, and hand-written flush/reset/back-to-back sequences.
module tb_muldiv_sequencer;

    localparam int W = 32;

    logic         clk;
    logic         i_reset;
    logic         i_start;
    logic         i_flush;
    logic [2:0]   i_funct3;
    logic [W-1:0] i_op_a;
    logic [W-1:0] i_op_b;
    logic         o_stall;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_result;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .i_clk    (clk),
        .i_reset  (i_reset),
        .i_start  (i_start),
        .i_flush  (i_flush),
        .i_funct3 (i_funct3),
        .i_op_a   (i_op_a),
        .i_op_b   (i_op_b),
        .o_stall  (o_stall),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_result (o_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   f;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        bit           special;
    } vec_t;

    int           n_checks = 0;
    int           n_err = 0;
    int           n_done = 0;
    int           exp_done = 0;
    int           cyc = 0;
    int           last_done_cyc = 0;
    logic [W-1:0] last_result = '0;
    logic [W-1:0] sb_q[$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (o_done) begin
            n_done++;
            last_done_cyc = cyc;
        end
    end

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input logic [2:0] f, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        logic ovf;
        sa  = $signed(a);
        sb  = $signed(b);
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'b000: begin p = sa * sb; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 0) return '1;
                if (ovf) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'b101: return (b == 0) ? '1 : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (ovf) return '0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp, input bit special, input bit flush_in_done);
        int edges;
        int stall_cyc;
        int busy_cyc;
        logic [W-1:0] want;
        @(negedge clk);
        i_start  = 1'b1;
        i_funct3 = f;
        i_op_a   = a;
        i_op_b   = b;
        sb_q.push_back(exp);
        exp_done++;
        #1;
        chk("stall_on_accept", {31'd0, o_stall}, 32'd1);
        stall_cyc = 1;
        busy_cyc  = 0;
        @(posedge clk);
        edges = 1;
        #1;
        // scramble inputs: the unit must work from latched operands
        i_start  = 1'b0;
        i_op_a   = ~a;
        i_op_b   = $urandom;
        i_funct3 = 3'($urandom);
        #1;
        while (!o_done && edges < W + 8) begin
            stall_cyc += int'(o_stall);
            busy_cyc  += int'(o_busy);
            @(posedge clk);
            edges++;
            #2;
        end
        chk("latency_edges", 32'(edges), special ? 32'd1 : 32'(W + 1));
        chk("stall_cycles", 32'(stall_cyc), special ? 32'd1 : 32'(W + 1));
        chk("busy_cycles", 32'(busy_cyc), special ? 32'd0 : 32'(W));
        want = sb_q.pop_front();
        chk("result", o_result, want);
        chk("stall_in_done", {31'd0, o_stall}, 32'd0);
        chk("busy_in_done", {31'd0, o_busy}, 32'd0);
        last_result = want;
        if (flush_in_done) i_flush = 1'b1;
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        chk("done_one_cycle", {31'd0, o_done}, 32'd0);
        chk("result_held", o_result, want);
    endtask

    vec_t vecs[$];

    initial begin
        vec_t v;
        int d1;
        i_reset  = 1'b1;
        i_start  = 1'b0;
        i_flush  = 1'b0;
        i_funct3 = '0;
        i_op_a   = '0;
        i_op_b   = '0;

        vecs.push_back('{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0});
        vecs.push_back('{3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0});
        vecs.push_back('{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0});
        vecs.push_back('{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0});
        vecs.push_back('{3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{3'b101, 32'd100,        32'd7,         32'd14,        1'b0});
        vecs.push_back('{3'b111, 32'd100,        32'd7,         32'd2,         1'b0});
        vecs.push_back('{3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1});
        vecs.push_back('{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b1});
        vecs.push_back('{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1});
        vecs.push_back('{3'b111, 32'd1234,       32'd0,         32'd1234,      1'b1});
        vecs.push_back('{3'b100, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0});
        vecs.push_back('{3'b110, 32'd9,          32'hFFFF_FFFC, 32'd1,         1'b0});

        #1;
        chk("reset_busy", {31'd0, o_busy}, 32'd0);
        chk("reset_done", {31'd0, o_done}, 32'd0);
        chk("reset_stall", {31'd0, o_stall}, 32'd0);
        chk("reset_result", o_result, 32'd0);
        repeat (2) @(negedge clk);
        i_reset = 1'b0;

        foreach (vecs[i]) begin
            v = vecs[i];
            run_op(v.f, v.a, v.b, v.exp, v.special, 1'b0);
        end

        for (int i = 0; i < 8; i++) begin
            logic [2:0]   f;
            logic [W-1:0] a;
            logic [W-1:0] b;
            bit           sp;
            f  = 3'(i);
            a  = $urandom;
            b  = (i == 5) ? 32'd0 : $urandom;
            sp = f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
            run_op(f, a, b, ref_op(f, a, b), sp, 1'b0);
        end

        // flush in DONE has no effect on the pulse or the result
        run_op(3'b101, 32'd77, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b1);

        // start and flush together in IDLE: not accepted
        @(negedge clk);
        i_start  = 1'b1;
        i_flush  = 1'b1;
        i_funct3 = 3'b000;
        i_op_a   = 32'd3;
        i_op_b   = 32'd4;
        #1;
        chk("start_flush_stall", {31'd0, o_stall}, 32'd0);
        @(posedge clk);
        #2;
        chk("start_flush_busy", {31'd0, o_busy}, 32'd0);
        i_start = 1'b0;
        i_flush = 1'b0;

        // flush at counter=10 during DIV
        @(negedge clk);
        i_start  = 1'b1;
        i_funct3 = 3'b100;
        i_op_a   = 32'd1000;
        i_op_b   = 32'd3;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("busy_before_flush", {31'd0, o_busy}, 32'd1);
        i_flush = 1'b1;
        @(posedge clk);
        #2;
        i_flush = 1'b0;
        chk("flush_busy", {31'd0, o_busy}, 32'd0);
        chk("flush_stall", {31'd0, o_stall}, 32'd0);
        chk("flush_done", {31'd0, o_done}, 32'd0);
        chk("flush_result_kept", o_result, last_result);
        repeat (W + 4) @(posedge clk);
        run_op(3'b100, 32'd1000, 32'd3, 32'd333, 1'b0, 1'b0);

        // back-to-back MUL then DIVU
        run_op(3'b000, 32'd12345, 32'd678, 32'd8369910, 1'b0, 1'b0);
        d1 = last_done_cyc;
        run_op(3'b101, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 1'b0, 1'b0);
        chk("back_to_back_gap", 32'(last_done_cyc - d1), 32'(W + 2));

        // asynchronous reset mid-CALC
        @(negedge clk);
        i_start  = 1'b1;
        i_funct3 = 3'b000;
        i_op_a   = 32'd5;
        i_op_b   = 32'd6;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        i_reset = 1'b1;
        #1;
        chk("mid_reset_busy", {31'd0, o_busy}, 32'd0);
        chk("mid_reset_stall", {31'd0, o_stall}, 32'd0);
        chk("mid_reset_done", {31'd0, o_done}, 32'd0);
        chk("mid_reset_result", o_result, 32'd0);
        @(negedge clk);
        i_reset = 1'b0;
        repeat (W + 4) @(posedge clk);
        run_op(3'b111, 32'd100, 32'd9, 32'd1, 1'b0, 1'b0);

        #1;
        chk("done_pulse_count", 32'(n_done), 32'(exp_done));
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
